// File: rtl/load_store_unit.sv
// load_store_unit
//   Execute-to-memory stage of the RV32I core. Uses the ALU result as the
//   effective address and runs one load or store per request against a
//   valid/ready data-memory port. Produces a word-aligned address, byte
//   enables and lane-replicated store data. Sign- or zero-extends load data
//   for writeback. Raises busy until the access completes. Flags misaligned
//   accesses, illegal funct3 codes and memory timeouts.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   req_valid          memory instruction present (held stable while busy)
//   req_write          1 = store, 0 = load
//   funct3             RV32I width/sign code
//   addr, wdata        effective address, store data (rs2)
//   busy               stall to core (combinational)
//   done               one-cycle completion pulse; rdata/fault valid with it
//   rdata              extended load result (0 for stores and faults)
//   fault              misaligned / illegal funct3 / timeout, valid with done
//   mem_req, mem_we    memory request valid, write enable
//   mem_addr, mem_be   word address, byte enables
//   mem_wdata          lane-replicated store data
//   mem_ready          memory completes request this cycle
//   mem_rdata          load word, valid with mem_ready
//
// Parameter
//   MAX_WAIT           number of unanswered WAIT cycles before a timeout
//                      fault is raised; 0 disables the timeout

module load_store_unit #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 2);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   maddr_q, maddr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   mwdata_q, mwdata_d;

    logic          legal, aligned, timeout;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    be_calc;
    logic [31:0]   wdata_calc;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;

    // Request decode: legality, alignment, byte enables, replicated store data
    always_comb begin
        if (req_write) legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else           legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                               (funct3 == 3'b100) || (funct3 == 3'b101);
        case (funct3[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        case (funct3[1:0])
            2'b00:   be_calc = 4'b0001 << addr[1:0];
            2'b01:   be_calc = addr[1] ? 4'b1100 : 4'b0011;
            default: be_calc = 4'b1111;
        endcase
        case (funct3[1:0])
            2'b00:   wdata_calc = {4{wdata[7:0]}};
            2'b01:   wdata_calc = {2{wdata[15:0]}};
            default: wdata_calc = wdata;
        endcase
    end

    // Load extraction uses the latched offset/funct3 so it does not depend on
    // the core keeping addr stable once the request is accepted.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // cnt_inc counts WAIT cycles including the current one
    assign cnt_inc = cnt_q + 1'b1;
    assign timeout = (MAX_WAIT != 0) && (cnt_inc == MAX_CNT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        off_d    = off_q;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        rdata_d  = rdata_q;
        req_d    = req_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        be_d     = be_q;
        mwdata_d = mwdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d  = funct3;
                    off_d = addr[1:0];
                    cnt_d = '0;
                    if (legal && aligned) begin
                        req_d    = 1'b1;
                        we_d     = req_write;
                        maddr_d  = {addr[31:2], 2'b00};
                        be_d     = be_calc;
                        mwdata_d = wdata_calc;
                        state_d  = WAIT;
                    end else begin
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                // ready takes priority over a coincident timeout
                if (mem_ready) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = we_q ? '0 : ld_ext;
                    state_d = RESP;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (MAX_WAIT != 0) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            off_q    <= '0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            be_q     <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            be_q     <= be_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign busy      = (state_q != IDLE) || req_valid;
    assign done      = done_q;
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_be    = be_q;
    assign mem_wdata = mwdata_q;

endmodule
